// File: rtl/cipher_out_fifo.sv
// Burst-oriented output buffer between the cipher core and the downstream
// byte sink. Bytes are collected in FILL, released as a burst in DRAIN with
// first-word fall-through, and any write while draining or when full parks
// the block in ERR until clr_err.
module cipher_out_fifo #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned BURST = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 stream,
    input  logic                       wt_sgn,
    input  logic                       flush,
    input  logic                       clr_err,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    output logic [1:0]                 fifo_cnd,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FILL  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_ERR   = 2'b11
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   wr_ptr_nxt;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_nxt;
    logic [LW-1:0]   level_nxt;
    logic [LW-1:0]   level_wr;
    logic            overflow_nxt;
    logic            out_valid_nxt;
    logic [7:0]      out_data_nxt;
    logic            wr_en;
    logic            rd_en;

    logic [7:0]      mem [DEPTH];

    // Condition code is the state encoding itself.
    assign fifo_cnd = state;

    // Next-state, pointer, level and registered-output computation.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        level_nxt     = level;
        level_wr      = level;
        overflow_nxt  = overflow;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        out_valid_nxt = 1'b0;
        out_data_nxt  = 8'h00;

        unique case (state)
            ST_EMPTY: begin
                // flush and out_ready have no meaning with nothing stored
                if (wt_sgn) begin
                    wr_en    = 1'b1;
                    level_wr = level + LW'(1);
                    state_nxt = (level_wr == LW'(BURST)) ? ST_DRAIN : ST_FILL;
                end
            end

            ST_FILL: begin
                if (wt_sgn && (level == LW'(DEPTH))) begin
                    overflow_nxt = 1'b1;
                    state_nxt    = ST_ERR;
                end else begin
                    if (wt_sgn) begin
                        wr_en    = 1'b1;
                        level_wr = level + LW'(1);
                    end
                    // burst release counts a write landing in the same cycle
                    if ((level_wr == LW'(BURST)) || (flush && (level_wr != '0))) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (wt_sgn) begin
                    // upstream must not write during a drain; no read this cycle
                    overflow_nxt = 1'b1;
                    state_nxt    = ST_ERR;
                end else if (level == '0) begin
                    state_nxt = ST_EMPTY;
                end else if (out_ready) begin
                    rd_en = 1'b1;
                    if (level == LW'(1)) begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end

            ST_ERR: begin
                if (clr_err) begin
                    state_nxt    = ST_EMPTY;
                    wr_ptr_nxt   = '0;
                    rd_ptr_nxt   = '0;
                    level_nxt    = '0;
                    overflow_nxt = 1'b0;
                end
            end

            default: state_nxt = ST_EMPTY;
        endcase

        if (wr_en) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
            level_nxt  = level_wr;
        end
        if (rd_en) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
            level_nxt  = level - LW'(1);
        end

        // Head byte is presented from a register; bypass the write when the
        // byte being stored is also the next head (buffer was empty).
        out_valid_nxt = (state_nxt == ST_DRAIN) && (level_nxt != '0);
        if (out_valid_nxt) begin
            if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
                out_data_nxt = stream;
            end else begin
                out_data_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // State, pointers, level and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            overflow  <= overflow_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end

    // Byte storage; contents are never observable before being written.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= stream;
        end
    end

endmodule

// File: tb/tb_cipher_out_fifo.sv
// Self-checking bench for cipher_out_fifo: a vector table for single-cycle
// behaviour plus scoreboarded burst sequences.
module tb_cipher_out_fifo;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned BURST = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  stream;
    logic        wt_sgn;
    logic        flush;
    logic        clr_err;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  fifo_cnd;
    logic [8:0]  level;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic       rst;
        logic       wt;
        logic [7:0] data;
        logic       fl;
        logic       clr;
        logic       rdy;
        logic [1:0] e_cnd;
        logic [8:0] e_lvl;
        logic       e_vld;
        logic [7:0] e_dat;
        logic       e_ovf;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    cipher_out_fifo #(.DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .stream    (stream),
        .wt_sgn    (wt_sgn),
        .flush     (flush),
        .clr_err   (clr_err),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .fifo_cnd  (fifo_cnd),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic w, input logic [7:0] d,
                                input logic f, input logic c, input logic rd,
                                input logic [1:0] cnd, input logic [8:0] lv,
                                input logic vl, input logic [7:0] dt, input logic ov);
        vec_t v;
        v.rst = r;  v.wt = w;  v.data = d;  v.fl = f;  v.clr = c;  v.rdy = rd;
        v.e_cnd = cnd;  v.e_lvl = lv;  v.e_vld = vl;  v.e_dat = dt;  v.e_ovf = ov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; wt_sgn = 1'b0; flush = 1'b0; clr_err = 1'b0;
        out_ready = 1'b0; stream = 8'h00;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        chk({tag, "_cnd"},   32'(fifo_cnd),  32'd0);
        chk({tag, "_level"}, 32'(level),     32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ovf"},   32'(overflow),  32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
    endtask

    task automatic wr(input logic [7:0] b);
        stream = b;
        wt_sgn = 1'b1;
        tick();
        wt_sgn = 1'b0;
        sb_q.push_back(b);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Drain the scoreboard; checks order, valid, and stall stability.
    task automatic drain(input bit rand_rdy, input string tag);
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic       rdy;
        while (sb_q.size() > 0 && cyc < 2000) begin
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            if (stalled) chk({tag, "_hold"}, 32'(out_data), 32'(held));
            out_ready = rdy;
            if (out_valid && rdy) chk({tag, "_data"}, 32'(out_data), 32'(sb_q.pop_front()));
            stalled = out_valid && !rdy;
            held    = out_data;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d bytes left, expected 0", tag, sb_q.size());
            sb_q.delete();
        end
        chk({tag, "_end_cnd"},   32'(fifo_cnd),  32'd0);
        chk({tag, "_end_level"}, 32'(level),     32'd0);
        chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        //            rst  wt  data   fl clr rdy  cnd    lvl   vld dat    ovf
        vecs[0]  = mk(1, 1, 8'h55, 0, 0, 0, 2'b00, 9'd0, 0, 8'h00, 0);
        vecs[1]  = mk(0, 1, 8'hA1, 0, 0, 0, 2'b01, 9'd1, 0, 8'h00, 0);
        vecs[2]  = mk(0, 1, 8'hA2, 0, 0, 1, 2'b01, 9'd2, 0, 8'h00, 0);
        vecs[3]  = mk(0, 1, 8'hA3, 0, 0, 0, 2'b01, 9'd3, 0, 8'h00, 0);
        vecs[4]  = mk(0, 1, 8'hA4, 0, 0, 0, 2'b01, 9'd4, 0, 8'h00, 0);
        vecs[5]  = mk(0, 1, 8'hA5, 0, 0, 0, 2'b01, 9'd5, 0, 8'h00, 0);
        vecs[6]  = mk(0, 0, 8'h00, 1, 0, 0, 2'b10, 9'd5, 1, 8'hA1, 0);
        vecs[7]  = mk(0, 0, 8'h00, 0, 0, 1, 2'b10, 9'd4, 1, 8'hA2, 0);
        vecs[8]  = mk(0, 0, 8'h00, 0, 0, 0, 2'b10, 9'd4, 1, 8'hA2, 0);
        vecs[9]  = mk(0, 0, 8'h00, 0, 0, 0, 2'b10, 9'd4, 1, 8'hA2, 0);
        vecs[10] = mk(0, 0, 8'h00, 0, 0, 1, 2'b10, 9'd3, 1, 8'hA3, 0);
        vecs[11] = mk(0, 0, 8'h00, 0, 0, 1, 2'b10, 9'd2, 1, 8'hA4, 0);
        vecs[12] = mk(0, 0, 8'h00, 0, 0, 1, 2'b10, 9'd1, 1, 8'hA5, 0);
        vecs[13] = mk(0, 0, 8'h00, 0, 0, 1, 2'b00, 9'd0, 0, 8'h00, 0);
        vecs[14] = mk(0, 0, 8'h00, 1, 0, 1, 2'b00, 9'd0, 0, 8'h00, 0);
        vecs[15] = mk(0, 0, 8'h00, 0, 1, 0, 2'b00, 9'd0, 0, 8'h00, 0);
        vecs[16] = mk(0, 1, 8'hB0, 0, 0, 0, 2'b01, 9'd1, 0, 8'h00, 0);
        vecs[17] = mk(0, 1, 8'hB1, 1, 0, 0, 2'b10, 9'd2, 1, 8'hB0, 0);
        vecs[18] = mk(0, 1, 8'hC0, 0, 0, 1, 2'b11, 9'd2, 0, 8'h00, 1);
        vecs[19] = mk(0, 1, 8'hC1, 0, 0, 1, 2'b11, 9'd2, 0, 8'h00, 1);
        vecs[20] = mk(0, 1, 8'hC2, 0, 1, 0, 2'b00, 9'd0, 0, 8'h00, 0);
        vecs[21] = mk(0, 1, 8'hD0, 1, 0, 0, 2'b01, 9'd1, 0, 8'h00, 0);
        vecs[22] = mk(0, 0, 8'h00, 1, 0, 0, 2'b10, 9'd1, 1, 8'hD0, 0);
        vecs[23] = mk(0, 0, 8'h00, 0, 0, 1, 2'b00, 9'd0, 0, 8'h00, 0);

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        do_reset("reset");

        // Single-cycle behaviour from the vector table
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst;  wt_sgn = vecs[i].wt;  stream = vecs[i].data;
            flush = vecs[i].fl; clr_err = vecs[i].clr; out_ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_cnd", i),   32'(fifo_cnd),  32'(vecs[i].e_cnd));
            chk($sformatf("vec%0d_level", i), 32'(level),     32'(vecs[i].e_lvl));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d_data", i),  32'(out_data),  32'(vecs[i].e_dat));
            chk($sformatf("vec%0d_ovf", i),   32'(overflow),  32'(vecs[i].e_ovf));
        end
        idle_inputs();

        // Full 256-byte burst with contiguous writes
        do_reset("rst_b256");
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wr(8'(i));
            if (i < 255) begin
                chk("b256_fill_cnd", 32'(fifo_cnd), 32'd1);
            end else begin
                chk("b256_full_cnd", 32'(fifo_cnd), 32'd2);
                chk("b256_full_head", 32'(out_data), 32'h00);
            end
            chk("b256_level", 32'(level), 32'(i + 1));
        end
        drain(1'b0, "b256");

        // Protocol error during drain, then recovery
        do_reset("rst_err");
        for (int i = 0; i < 10; i++) wr(8'(8'h40 + i));
        do_flush();
        chk("err_pre_cnd",   32'(fifo_cnd), 32'd2);
        chk("err_pre_level", 32'(level),    32'd10);
        out_ready = 1'b1;
        wr(8'hEE);
        chk("err_cnd",   32'(fifo_cnd),  32'd3);
        chk("err_ovf",   32'(overflow),  32'd1);
        chk("err_valid", 32'(out_valid), 32'd0);
        chk("err_level", 32'(level),     32'd10);
        wr(8'hEF);
        chk("err_hold_cnd",   32'(fifo_cnd), 32'd3);
        chk("err_hold_level", 32'(level),    32'd10);
        out_ready = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        sb_q.delete();
        chk("clr_cnd",   32'(fifo_cnd),  32'd0);
        chk("clr_level", 32'(level),     32'd0);
        chk("clr_ovf",   32'(overflow),  32'd0);
        chk("clr_valid", 32'(out_valid), 32'd0);
        wr(8'h77);
        do_flush();
        drain(1'b0, "post_clr");

        // Pointer wrap past DEPTH with random stalls
        do_reset("rst_wrap");
        for (int i = 0; i < 200; i++) wr(8'($urandom_range(0, 255)));
        do_flush();
        drain(1'b0, "pre_wrap");
        for (int i = 0; i < 120; i++) wr(8'($urandom_range(0, 255)));
        do_flush();
        chk("wrap_level", 32'(level), 32'd120);
        drain(1'b1, "wrap");

        // Reset mid-burst after the pointers have advanced
        do_reset("rst_mid");
        for (int i = 0; i < 100; i++) wr(8'(i + 1));
        do_flush();
        drain(1'b0, "mid_a");
        for (int i = 0; i < 100; i++) wr(8'(8'h80 + i));
        do_flush();
        chk("mid_level", 32'(level),    32'd100);
        chk("mid_cnd",   32'(fifo_cnd), 32'd2);
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        sb_q.delete();
        chk("mid_rst_level", 32'(level),     32'd0);
        chk("mid_rst_cnd",   32'(fifo_cnd),  32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        wr(8'h31);
        wr(8'h32);
        wr(8'h33);
        do_flush();
        chk("mid_b3_level", 32'(level), 32'd3);
        drain(1'b1, "mid_b3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cipher_out_fifo.md
CIPHER_OUT_FIFO -- requirements
Module: cipher_out_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 256: storage depth in bytes.
REQ-002 SHALL have parameter BURST, default 256: bytes per cipher burst; BURST <= DEPTH, both powers of two.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stream  input  8  encrypted byte from the upstream cipher core.
REQ-006 SHALL have port wt_sgn  input  1  write strobe; one byte per high cycle.
REQ-007 SHALL have port flush  input  1  release a partial burst for draining.
REQ-008 SHALL have port clr_err  input  1  leave the error state and clear the buffer.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 SHALL have port out_data  output  8  head byte of the buffer.
REQ-011 SHALL have port out_valid  output  1  out_data is valid.
REQ-012 SHALL have port fifo_cnd  output  2  buffer condition reported back to the cipher core.
REQ-013 SHALL have port level  output  log2(DEPTH)+1  number of stored bytes.
REQ-014 SHALL have port overflow  output  1  sticky flag: a byte was dropped.

Function
REQ-015 SHALL implement the state machine EMPTY, FILL, DRAIN and ERR, with fifo_cnd driven as 00, 01, 10 and 11 respectively, taken straight from the state register.
REQ-016 SHALL, in EMPTY, move to FILL when wt_sgn=1 and store that byte; flush and out_ready are ignored.
REQ-017 SHALL, in FILL, store each wt_sgn byte at the write pointer and increment level.
REQ-018 SHALL, in FILL, move to DRAIN when level reaches BURST, counting a write in the same cycle.
REQ-019 SHALL, in FILL, also move to DRAIN on flush=1 with level>0 after any same-cycle write.
REQ-020 SHALL, in FILL, move to ERR on wt_sgn=1 with level==DEPTH, dropping the byte and setting overflow.
REQ-021 SHALL hold out_valid=0 in every state except DRAIN.
REQ-022 SHALL, in DRAIN, drive out_valid=1 whenever level>0, with out_data equal to the oldest stored byte (first-word fall-through, zero read latency).
REQ-023 SHALL, in DRAIN, transfer one byte per cycle on out_valid=1 and out_ready=1, advancing the read pointer and decrementing level.
REQ-024 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL move from DRAIN to EMPTY in the cycle after the last byte transfers, so fifo_cnd=00 and level=0 then.
REQ-026 SHALL, in DRAIN, treat wt_sgn=1 as a protocol error: drop the byte, set overflow, move to ERR, and not perform any read that cycle.
REQ-027 SHALL, in ERR, drop all writes, ignore reads, and keep fifo_cnd=11.
REQ-028 SHALL, in ERR with clr_err=1, go to EMPTY, zero the pointers, level and overflow, and not store a same-cycle wt_sgn byte.
REQ-029 SHALL ignore clr_err outside ERR.
REQ-030 SHALL wrap the read and write pointers modulo DEPTH, with level unaffected by the wrap.
REQ-031 SHALL keep the stored bytes in write order with no reordering or duplication.

Reset
REQ-032 SHALL, when rst=1 at a clock edge, force state EMPTY, fifo_cnd=00, level=0, pointers=0, overflow=0, out_valid=0 and out_data=0, overriding all other inputs, including mid-burst.
REQ-033 SHALL not require the storage array to be reset; its contents are unobservable while out_valid=0.

Verification
REQ-034 SHALL be verified by: rst pulse -> fifo_cnd=00, level=0, out_valid=0, overflow=0.
REQ-035 SHALL be verified by: 256 contiguous writes 0x00..0xFF, out_ready=1 -> fifo_cnd=01 during fill and 10 after the 256th write; out_data 0x00..0xFF in order, one per cycle; fifo_cnd=00 the cycle after 0xFF transfers.
REQ-036 SHALL be verified by: writes 0xA1..0xA5 then flush -> DRAIN with level=5; five bytes out in order; back to EMPTY.
REQ-037 SHALL be verified by: out_ready toggled 1,0,0,1 during DRAIN -> out_data unchanged across the stall cycles; no byte lost or repeated.
REQ-038 SHALL be verified by: wt_sgn=1 while in DRAIN with level=10 -> fifo_cnd=11, overflow=1, out_valid=0; then clr_err=1 -> fifo_cnd=00, level=0, overflow=0.
REQ-039 SHALL be verified by: rst=1 in DRAIN at level=100 with 200 total writes, so the pointers have advanced -> next cycle level=0, fifo_cnd=00, out_valid=0; a following 3-byte burst plus flush drains correctly.
